// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type and the sigma/rotate helpers
// used by the compression core and its message schedule.
package sha256_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ROUND = 2'd1,
        FINAL = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] H0 [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] rotr32(input logic [31:0] x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr32(x, 2) ^ rotr32(x, 13) ^ rotr32(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr32(x, 6) ^ rotr32(x, 11) ^ rotr32(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr32(x, 7) ^ rotr32(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr32(x, 17) ^ rotr32(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/sha256_compress_core_if.sv
// Block-in / digest-out handshake bundle of the compression core.
interface sha256_compress_core_if;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_block;
    logic         in_use_iv;
    logic [255:0] in_hash;
    logic         out_valid;
    logic         out_ready;
    logic [255:0] out_digest;
    logic         busy;

    modport master (
        output in_valid, in_block, in_use_iv, in_hash, out_ready,
        input  in_ready, out_valid, out_digest, busy
    );

    modport slave (
        input  in_valid, in_block, in_use_iv, in_hash, out_ready,
        output in_ready, out_valid, out_digest, busy
    );
endinterface

// File: rtl/ch.sv
// Bitwise choose: x selects y where set, z where clear.
module ch #(
    parameter int WORDSIZE = 32
) (
    input  logic [WORDSIZE-1:0] x,
    input  logic [WORDSIZE-1:0] y,
    input  logic [WORDSIZE-1:0] z,
    output logic [WORDSIZE-1:0] c
);
    assign c = (x & y) | (~x & z);
endmodule

// File: rtl/maj.sv
// Bitwise majority of three words.
module maj #(
    parameter int WORDSIZE = 32
) (
    input  logic [WORDSIZE-1:0] x,
    input  logic [WORDSIZE-1:0] y,
    input  logic [WORDSIZE-1:0] z,
    output logic [WORDSIZE-1:0] m
);
    assign m = (x & y) | (x & z) | (y & z);
endmodule

// File: rtl/sha256_msg_schedule.sv
// Sixteen-word sliding message window; w_t is the word for the current round.
module sha256_msg_schedule
    import sha256_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         shift,
    input  logic [511:0] block,
    output logic [31:0]  w_t
);
    logic [31:0] w [16];
    logic [31:0] w_new;

    assign w_new = small_sigma1(w[14]) + w[9] + small_sigma0(w[1]) + w[0];
    assign w_t   = w[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) w[i] <= '0;
        end else if (load) begin
            for (int i = 0; i < 16; i++) w[i] <= block[511-32*i -: 32];
        end else if (shift) begin
            for (int i = 0; i < 15; i++) w[i] <= w[i+1];
            w[15] <= w_new;
        end
    end
endmodule

// File: rtl/sha256_compress_core.sv
// Iterative SHA-256 compression: one round per clock, 65 cycles from accept to digest.
module sha256_compress_core
    import sha256_pkg::*;
#(
    parameter int WORDSIZE   = 32,
    parameter int NUM_ROUNDS = 64
) (
    input logic                   clk,
    input logic                   rst_n,
    sha256_compress_core_if.slave bus
);
    // state | meaning
    // IDLE  | ready for a block; digest of previous block still on out_digest
    // ROUND | one compression round per cycle, rnd = current round
    // FINAL | fold working vars into the chaining value
    // DONE  | digest presented, waiting for out_ready
    localparam int RND_W = $clog2(NUM_ROUNDS);
    localparam logic [RND_W-1:0] RND_LAST = RND_W'(NUM_ROUNDS - 1);

    state_t state, state_nxt;

    logic [RND_W-1:0] rnd;
    logic [31:0]      a, b, c, d, e, f, g, h;
    logic [31:0]      hreg  [8];
    logic [31:0]      chain [8];
    logic [255:0]     digest_q;
    logic [31:0]      w_t, maj_abc, ch_efg, t1, t2;
    logic             load_w, round_en, final_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nxt = ROUND;
            ROUND:   if (rnd == RND_LAST) state_nxt = FINAL;
            FINAL:   state_nxt = DONE;
            DONE:    if (bus.out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.busy      = 1'b0;
        load_w        = 1'b0;
        round_en      = 1'b0;
        final_en      = 1'b0;
        case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                load_w       = bus.in_valid;
            end
            ROUND: begin
                bus.busy = 1'b1;
                round_en = 1'b1;
            end
            FINAL: begin
                bus.busy = 1'b1;
                final_en = 1'b1;
            end
            DONE:    bus.out_valid = 1'b1;
            default: ;
        endcase
    end

    sha256_msg_schedule u_sched (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_w),
        .shift (round_en),
        .block (bus.in_block),
        .w_t   (w_t)
    );

    maj #(.WORDSIZE(WORDSIZE)) u_maj (.x(a), .y(b), .z(c), .m(maj_abc));
    ch  #(.WORDSIZE(WORDSIZE)) u_ch  (.x(e), .y(f), .z(g), .c(ch_efg));

    assign t1 = h + big_sigma1(e) + ch_efg + K[rnd] + w_t;
    assign t2 = big_sigma0(a) + maj_abc;

    always_comb begin
        for (int i = 0; i < 8; i++)
            chain[i] = bus.in_use_iv ? H0[i] : bus.in_hash[255-32*i -: 32];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rnd      <= '0;
            digest_q <= '0;
            {a, b, c, d, e, f, g, h} <= '0;
            for (int i = 0; i < 8; i++) hreg[i] <= '0;
        end else if (load_w) begin
            rnd <= '0;
            for (int i = 0; i < 8; i++) hreg[i] <= chain[i];
            {a, b, c, d, e, f, g, h} <= {chain[0], chain[1], chain[2], chain[3],
                                         chain[4], chain[5], chain[6], chain[7]};
        end else if (round_en) begin
            // rnd wraps to 0 on the last round, leaving it clean for the next block
            rnd <= rnd + 1'b1;
            h   <= g;
            g   <= f;
            f   <= e;
            e   <= d + t1;
            d   <= c;
            c   <= b;
            b   <= a;
            a   <= t1 + t2;
        end else if (final_en) begin
            digest_q <= {hreg[0] + a, hreg[1] + b, hreg[2] + c, hreg[3] + d,
                         hreg[4] + e, hreg[5] + f, hreg[6] + g, hreg[7] + h};
        end
    end

    assign bus.out_digest = digest_q;
endmodule

// File: tb/tb_sha256_compress_core.sv
// Directed and randomized checks of sha256_compress_core against a plain SHA-256 model.
module tb_sha256_compress_core;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sha256_compress_core_if bus ();

    sha256_compress_core #(.WORDSIZE(32), .NUM_ROUNDS(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [31:0] KR [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };
    localparam logic [255:0] IV_REF =
        256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

    localparam logic [511:0] ABC_BLK   = {32'h61626380, 448'd0, 32'h00000018};
    localparam logic [511:0] EMPTY_BLK = {32'h80000000, 480'd0};
    localparam logic [511:0] TWO_BLK1  = {
        32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] TWO_BLK2  = {480'd0, 32'h000001c0};
    localparam logic [255:0] ABC_DIG   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [255:0] TWO_DIG   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook SHA-256 compression with the full 64-word schedule expanded up front.
    function automatic logic [255:0] ref_compress(input logic [511:0] blk, input logic [255:0] hin);
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] hv [8];
        logic [31:0] s0, s1, t1, t2;
        logic [255:0] r;
        for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
        for (int i = 16; i < 64; i++) begin
            s0 = rr(w[i-15], 7) ^ rr(w[i-15], 18) ^ (w[i-15] >> 3);
            s1 = rr(w[i-2], 17) ^ rr(w[i-2], 19) ^ (w[i-2] >> 10);
            w[i] = w[i-16] + s0 + w[i-7] + s1;
        end
        for (int i = 0; i < 8; i++) begin
            hv[i] = hin[255-32*i -: 32];
            v[i]  = hv[i];
        end
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KR[t] + w[t];
            t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int j = 7; j > 0; j--) v[j] = v[j-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) r[255-32*i -: 32] = hv[i] + v[i];
        return r;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, want);
        end
    endtask

    task automatic run_block(input string tag, input logic [511:0] blk, input bit use_iv,
                             input logic [255:0] hin, input int hold, input bit noise,
                             output logic [255:0] dig);
        logic [255:0] want;
        int lat;
        want = ref_compress(blk, use_iv ? IV_REF : hin);
        @(negedge clk);
        bus.in_block  = blk;
        bus.in_use_iv = use_iv;
        bus.in_hash   = hin;
        bus.in_valid  = 1'b1;
        chk({tag, " in_ready idle"}, 256'(bus.in_ready), 256'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        chk({tag, " busy after accept"}, 256'(bus.busy), 256'd1);
        chk({tag, " in_ready after accept"}, 256'(bus.in_ready), 256'd0);
        lat = 0;
        while (!bus.out_valid && lat < 200) begin
            if (noise) begin
                bus.in_valid  = 1'($urandom);
                bus.in_block  = rand512();
                bus.in_use_iv = 1'($urandom);
                bus.in_hash   = rand256();
                bus.out_ready = 1'($urandom);
            end
            @(posedge clk);
            #1;
            lat++;
        end
        bus.out_ready = 1'b0;
        chk({tag, " latency"}, 256'(lat), 256'd65);
        chk({tag, " digest"}, bus.out_digest, want);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk({tag, " hold out_valid"}, 256'(bus.out_valid), 256'd1);
            chk({tag, " hold digest"}, bus.out_digest, want);
            chk({tag, " hold in_ready"}, 256'(bus.in_ready), 256'd0);
        end
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({tag, " out_valid after accept"}, 256'(bus.out_valid), 256'd0);
        chk({tag, " in_ready after release"}, 256'(bus.in_ready), 256'd1);
        dig = bus.out_digest;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not complete");
    end

    initial begin
        logic [255:0] dig;
        logic [255:0] dig1;
        logic [511:0] rblk;
        checks = 0;
        errors = 0;
        bus.in_valid  = 1'b0;
        bus.in_block  = '0;
        bus.in_use_iv = 1'b0;
        bus.in_hash   = '0;
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset in_ready", 256'(bus.in_ready), 256'd1);
        chk("reset out_valid", 256'(bus.out_valid), 256'd0);
        chk("reset busy", 256'(bus.busy), 256'd0);
        chk("reset digest", bus.out_digest, 256'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_block("abc", ABC_BLK, 1'b1, rand256(), 0, 1'b0, dig);
        chk("abc known digest", dig, ABC_DIG);

        run_block("empty", EMPTY_BLK, 1'b1, '0, 1, 1'b0, dig);
        chk("empty known digest", dig, EMPTY_DIG);

        run_block("two blk1", TWO_BLK1, 1'b1, '0, 0, 1'b0, dig1);
        run_block("two blk2", TWO_BLK2, 1'b0, dig1, 0, 1'b0, dig);
        chk("two-block known digest", dig, TWO_DIG);

        run_block("backpressure", ABC_BLK, 1'b1, '0, 20, 1'b0, dig);
        chk("backpressure known digest", dig, ABC_DIG);

        // Abort at round 30 with a mid-cycle reset.
        @(negedge clk);
        bus.in_block  = EMPTY_BLK;
        bus.in_use_iv = 1'b1;
        bus.in_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (30) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("midreset in_ready", 256'(bus.in_ready), 256'd1);
        chk("midreset out_valid", 256'(bus.out_valid), 256'd0);
        chk("midreset busy", 256'(bus.busy), 256'd0);
        chk("midreset digest", bus.out_digest, 256'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("midreset out_valid held", 256'(bus.out_valid), 256'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            chk("after reset no out_valid", 256'(bus.out_valid), 256'd0);
        end
        run_block("abc after reset", ABC_BLK, 1'b1, '0, 0, 1'b0, dig);
        chk("abc after reset known digest", dig, ABC_DIG);

        run_block("ignore inputs in round", rand512(), 1'b0, rand256(), 3, 1'b1, dig);

        for (int n = 0; n < 6; n++) begin
            rblk = rand512();
            run_block($sformatf("random %0d", n), rblk, 1'($urandom), rand256(),
                      int'($urandom_range(0, 5)), 1'($urandom), dig);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
